// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - LCD character parser shared states, code constants and hex-to-code table
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } lcd_state_e;

    localparam logic [7:0] LCD_DIGIT_BASE     = 8'h30;
    localparam logic [7:0] LCD_LETTER_BASE    = 8'h81;
    localparam logic [7:0] LCD_TERM_DEFAULT   = 8'h0D;
    localparam logic [7:0] LCD_CANCEL_DEFAULT = 8'h1B;

    // Nibble-to-code table, also used by the display path to render hex values
    localparam logic [7:0] LCD_HEX_CODE [16] = '{
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86
    };

    function automatic logic [7:0] hex_to_lcd(input logic [3:0] nib);
        return LCD_HEX_CODE[nib];
    endfunction

endpackage

// File: rtl/lcd_code_to_hex.sv
// rtl/lcd_code_to_hex.sv - combinational LCD character code classifier and nibble decoder
module lcd_code_to_hex
    import lcd_pkg::*;
#(
    parameter logic [7:0] TERM_CODE   = LCD_TERM_DEFAULT,
    parameter logic [7:0] CANCEL_CODE = LCD_CANCEL_DEFAULT
) (
    input  logic [7:0] code,
    output logic [3:0] nibble,
    output logic       is_digit,
    output logic       is_term,
    output logic       is_cancel
);

    logic is_num;
    logic is_letter;

    assign is_num    = (code >= LCD_DIGIT_BASE)  && (code <= LCD_DIGIT_BASE + 8'd9);
    assign is_letter = (code >= LCD_LETTER_BASE) && (code <= LCD_LETTER_BASE + 8'd5);

    assign is_digit  = is_num || is_letter;
    assign is_term   = (code == TERM_CODE);
    assign is_cancel = (code == CANCEL_CODE);

    // 0x30..0x39 carry the value in the low nibble; 0x81..0x86 are offset by 9
    always_comb begin
        nibble = 4'd0;
        if (is_num) begin
            nibble = code[3:0];
        end else if (is_letter) begin
            nibble = code[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/lcd_char_parse.sv
// rtl/lcd_char_parse.sv - assembles LCD hex character streams into words; LCD_PARSE_ECHO_EN adds digit echo
module lcd_char_parse
    import lcd_pkg::*;
#(
    parameter int         DIGITS      = 4,
    parameter logic [7:0] TERM_CODE   = LCD_TERM_DEFAULT,
    parameter logic [7:0] CANCEL_CODE = LCD_CANCEL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    output logic [4*DIGITS-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [3:0]            ndig,
    output logic                  err
`ifdef LCD_PARSE_ECHO_EN
    ,
    output logic [7:0]            echo_code,
    output logic                  echo_valid
`endif
);

    localparam int W = 4 * DIGITS;

    lcd_state_e      state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [3:0]      count_q, count_d;
    logic            err_q, err_d;

    logic [3:0]      nibble;
    logic            is_digit;
    logic            is_term;
    logic            is_cancel;
    logic            accept;
    logic [W+3:0]    shift_ext;

    lcd_code_to_hex #(
        .TERM_CODE   (TERM_CODE),
        .CANCEL_CODE (CANCEL_CODE)
    ) u_code_to_hex (
        .code      (char_in),
        .nibble    (nibble),
        .is_digit  (is_digit),
        .is_term   (is_term),
        .is_cancel (is_cancel)
    );

    assign char_ready = (state_q != ST_HOLD);
    assign accept     = char_valid && char_ready;
    assign shift_ext  = {shift_q, nibble};
    assign word_out   = shift_q;
    assign ndig       = count_q;
    assign word_valid = (state_q == ST_HOLD);
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    if (is_cancel) begin
                        state_d = ST_IDLE;
                    end else if (is_term) begin
                        // A terminator with nothing accumulated is silently consumed
                        state_d = (state_q == ST_ACCUM) ? ST_HOLD : ST_IDLE;
                    end else if (is_digit) begin
                        if (count_q < 4'(DIGITS)) begin
                            shift_d = shift_ext[W-1:0];
                            count_d = count_q + 4'd1;
                            state_d = ST_ACCUM;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (accept && (is_term || is_cancel)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Any transition into IDLE starts the next word from a clean slate
        if (state_d == ST_IDLE) begin
            shift_d = '0;
            count_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef LCD_PARSE_ECHO_EN
    logic [7:0] echo_code_q;
    logic       echo_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_code_q  <= 8'h00;
            echo_valid_q <= 1'b0;
        end else begin
            echo_valid_q <= accept && is_digit;
            if (accept && is_digit) begin
                echo_code_q <= char_in;
            end
        end
    end

    assign echo_code  = echo_code_q;
    assign echo_valid = echo_valid_q;
`endif

endmodule

// File: tb/tb_lcd_char_parse.sv
// tb/tb_lcd_char_parse.sv - scoreboard bench for lcd_char_parse (echo checks when LCD_PARSE_ECHO_EN is defined)
module tb_lcd_char_parse;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  ndig;
    logic        err;
`ifdef LCD_PARSE_ECHO_EN
    logic [7:0]  echo_code;
    logic        echo_valid;
    logic [7:0]  exp_echo_q [$];
`endif

    int checks = 0;
    int errors = 0;
    int wv_cycles = 0;

    typedef struct packed {
        logic [15:0] word;
        logic [3:0]  nd;
    } exp_word_t;

    exp_word_t exp_word_q [$];
    int        exp_err_q  [$];

    lcd_char_parse #(.DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ndig       (ndig),
        .err        (err)
`ifdef LCD_PARSE_ECHO_EN
        ,
        .echo_code  (echo_code),
        .echo_valid (echo_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor samples mid-cycle; a word handshake completes at the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (word_valid) wv_cycles++;
            if (word_valid && word_ready) begin
                if (exp_word_q.size() == 0) begin
                    check("unexpected_word", {16'h0, word_out}, 32'hFFFFFFFF);
                end else begin
                    exp_word_t e;
                    e = exp_word_q.pop_front();
                    check("word_out", {16'h0, word_out}, {16'h0, e.word});
                    check("ndig", {28'h0, ndig}, {28'h0, e.nd});
                end
            end
            if (err) begin
                if (exp_err_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
                else check("err_pulse", 32'(err), 32'(exp_err_q.pop_front() != 0));
            end
`ifdef LCD_PARSE_ECHO_EN
            if (echo_valid) begin
                if (exp_echo_q.size() == 0) check("unexpected_echo", {24'h0, echo_code}, 32'hFFFFFFFF);
                else check("echo_code", {24'h0, echo_code}, {24'h0, exp_echo_q.pop_front()});
            end
`endif
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        char_in    = b;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("char_ready_timeout", 32'd0, 32'd1);
`ifdef LCD_PARSE_ECHO_EN
        if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h81 && b <= 8'h86)) exp_echo_q.push_back(b);
`endif
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        char_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_word_valid();
        int n;
        n = 0;
        while (!word_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("word_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_word(input logic [15:0] w, input logic [3:0] nd);
        exp_word_t e;
        e.word = w;
        e.nd   = nd;
        exp_word_q.push_back(e);
    endtask

    task automatic drained(input string name);
        check({name, "_words_left"}, exp_word_q.size(), 0);
        check({name, "_errs_left"}, exp_err_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_ready", 32'(char_ready), 32'd1);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ndig", {28'h0, ndig}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1A6F, four digits, immediate accept
        wv_cycles = 0;
        expect_word(16'h1A6F, 4'd4);
        send(8'h31); send(8'h81); send(8'h36); send(8'h86); send(8'h0D);
        idle(5);
        check("t1_wv_cycles", wv_cycles, 1);
        drained("t1");

        // 0029 held under backpressure
        word_ready = 1'b0;
        expect_word(16'h0029, 4'd2);
        send(8'h32); send(8'h39); send(8'h0D);
        char_valid = 1'b0;
        wait_word_valid();
        repeat (5) begin
            check("t2_hold_valid", 32'(word_valid), 32'd1);
            check("t2_hold_word", {16'h0, word_out}, 32'h0029);
            check("t2_hold_ndig", {28'h0, ndig}, 32'd2);
            check("t2_hold_ready", 32'(char_ready), 32'd0);
            @(posedge clk); #1;
        end
        word_ready = 1'b1;
        idle(3);
        drained("t2");

        // overflow on fifth digit, remainder discarded
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        exp_err_q.push_back(1);
        send(8'h35); send(8'h36); send(8'h0D);
        idle(4);
        check("t3_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        drained("t3");

        // invalid code then lone terminator
        send(8'h31);
        exp_err_q.push_back(1);
        send(8'h41); send(8'h0D);
        idle(4);
        drained("t4a");
        send(8'h0D);
        idle(4);
        check("t4b_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        drained("t4b");

        // cancel restarts the word
        expect_word(16'h0003, 4'd1);
        send(8'h37); send(8'h38); send(8'h1B); send(8'h33); send(8'h0D);
        idle(4);
        drained("t5");

        // reset during HOLD drops the pending word
        word_ready = 1'b0;
        send(8'h31); send(8'h0D);
        char_valid = 1'b0;
        wait_word_valid();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        word_ready = 1'b1;
        check("t6_wv_after_rst", 32'(word_valid), 32'd0);
        check("t6_ready_after_rst", 32'(char_ready), 32'd1);
        expect_word(16'h0005, 4'd1);
        send(8'h35); send(8'h0D);
        idle(5);
        drained("t6");
`ifdef LCD_PARSE_ECHO_EN
        check("t6_echo_left", exp_echo_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_char_parse.md
LCD_CHAR_PARSE -- requirements
Module: lcd_char_parse

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the maximum number of hex digits accumulated per word (range 1..8).
REQ-002 Parameter TERM_CODE, default 8'h0D, SHALL set the character code that ends a word.
REQ-003 Parameter CANCEL_CODE, default 8'h1B, SHALL set the character code that aborts the current word.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 char_in  in  8  LCD character code offered by the upstream block.
REQ-007 char_valid  in  1  char_in is valid this cycle.
REQ-008 char_ready  out  1  the block accepts char_in this cycle.
REQ-009 word_out  out  4*DIGITS  assembled value, with the first digit received in the most significant position.
REQ-010 word_valid  out  1  word_out and ndig are valid.
REQ-011 word_ready  in  1  downstream accepts the word.
REQ-012 ndig  out  4  number of digits in word_out.
REQ-013 err  out  1  one-cycle pulse on a malformed word.

Function
REQ-014 Character map SHALL be: 8'h30..8'h39 maps to nibbles 0..9; 8'h81..8'h86 maps to nibbles A..F; all other codes except TERM_CODE and CANCEL_CODE are invalid.
REQ-015 A character SHALL be accepted only in a cycle where char_valid and char_ready are both high.
REQ-016 The state machine SHALL have the states IDLE, ACCUM, HOLD and DISCARD.
REQ-017 char_ready SHALL be high in IDLE, ACCUM and DISCARD, and low in HOLD.
REQ-018 On an accepted digit in IDLE or ACCUM with count < DIGITS, the shift register SHALL become {shift[4*DIGITS-5:0], nibble}, count SHALL increment, and the state SHALL go to ACCUM.
REQ-019 On an accepted digit with count == DIGITS (overflow), err SHALL pulse for one cycle and the state SHALL go to DISCARD.
REQ-020 On an accepted invalid code in IDLE or ACCUM, err SHALL pulse for one cycle and the state SHALL go to DISCARD.
REQ-021 On an accepted TERM_CODE in ACCUM, the state SHALL go to HOLD, with word_valid high the following cycle (latency 1); word_out SHALL be the shift register zero-extended on the left, and ndig SHALL equal count.
REQ-022 On an accepted TERM_CODE in IDLE, the character SHALL be consumed with no output and no err.
REQ-023 In DISCARD, all characters SHALL be consumed without effect; TERM_CODE SHALL return the state to IDLE with no word and no further err.
REQ-024 On an accepted CANCEL_CODE in IDLE, ACCUM or DISCARD, the shift register and count SHALL clear and the state SHALL go to IDLE with no err.
REQ-025 In HOLD, word_out, ndig and word_valid SHALL stay stable until word_ready is high; on that handshake the state SHALL go to IDLE, and the shift register and count SHALL clear in the same cycle.
REQ-026 Entering IDLE from any state SHALL clear the shift register and count.
REQ-027 Back-to-back operation SHALL be supported: a character may be accepted in the cycle after the HOLD handshake.

Reset
REQ-028 While rst_n is low at a clock edge, the state SHALL become IDLE, the shift register and count SHALL become 0, word_valid and err SHALL become 0, and char_ready SHALL become 1 from the following cycle.
REQ-029 Reset asserted mid-word or in HOLD SHALL drop the pending word silently, with no err pulse.

Configuration
REQ-030 Macro LCD_PARSE_ECHO_EN, when defined, SHALL add the outputs echo_code[7:0] and echo_valid; each accepted digit SHALL drive echo_valid high for one cycle, with echo_code equal to the accepted char_in, on the cycle after acceptance.
REQ-031 Without LCD_PARSE_ECHO_EN, the echo ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package lcd_pkg SHALL hold the state enumeration, the code constants (digit base 8'h30, letter base 8'h81, TERM and CANCEL defaults) and the nibble-to-code table shared with the display path.
REQ-033 The code-to-nibble classification SHALL be a combinational sub-module lcd_code_to_hex with outputs nibble[3:0], is_digit, is_term and is_cancel.

Verification
REQ-034 The bench SHALL feed 31,81,36,86,0D with word_ready=1 and check word_out=16'h1A6F, ndig=4, word_valid for exactly one cycle, and err never asserted.
REQ-035 The bench SHALL feed 32,39,0D with word_ready held low for 5 cycles and check word_out=16'h0029, ndig=2, word_valid stable, char_ready=0 throughout, then release word_ready.
REQ-036 The bench SHALL feed 31,32,33,34,35 and check that err pulses on the 5th digit, then feed 36,0D and check that no word is produced and the block is back in IDLE.
REQ-037 The bench SHALL feed 31,41,0D and check that err pulses once on 41 and no word is produced; it SHALL then feed 0D alone and check there is no output and no err.
REQ-038 The bench SHALL feed 37,38,1B,33,0D and check word_out=16'h0003 with ndig=1.
REQ-039 The bench SHALL assert rst_n low during HOLD, then feed 35,0D and check that only word 16'h0005 appears; with LCD_PARSE_ECHO_EN defined it SHALL check that echo_code=35 pulses once.
